debug_in: RTL

Human-input front end for the single-cycle CPU debug harness, the input-side counterpart of the seven-segment debug display. It synchronizes and debounces the board push-buttons and converts presses into single-cycle CPU clock-enable steps, an optional free-run mode, and the display-select code. It also supplies the `disp_clock_count` and `disp_control` values consumed by the display driver.

---
 rtl/debug_pkg.sv | 9 +
 rtl/debug_in_if.sv | 14 +
 rtl/debounce.sv | 39 +++
 rtl/debug_in.sv | 56 +++++
 4 files changed

// File: rtl/debug_pkg.sv
// debug_pkg: shared constants and types for the debug-harness input front end.
package debug_pkg;
   localparam int DBC_W = 16;
   localparam logic [1:0] DISP_TEST_LO   = 2'b00;
   localparam logic [1:0] DISP_TEST_HI   = 2'b01;
   localparam logic [1:0] DISP_PC        = 2'b10;
   localparam logic [1:0] DISP_CLK_COUNT = 2'b11;
   typedef enum logic {STEP_IDLE, STEP_FIRE} step_state_t;
endpackage

// File: rtl/debug_in_if.sv
// debug_in_if: raw buttons in, CPU step/display controls out.
interface debug_in_if;
   logic       btn_step;
   logic       btn_mode;
   logic       btn_run;
   logic       cpu_clock_en;
   logic [7:0] disp_clock_count;
   logic [1:0] disp_control;
   logic       run_mode;
   modport master (output btn_step, btn_mode, btn_run,
                   input  cpu_clock_en, disp_clock_count, disp_control, run_mode);
   modport slave  (input  btn_step, btn_mode, btn_run,
                   output cpu_clock_en, disp_clock_count, disp_control, run_mode);
endinterface

// File: rtl/debounce.sv
// debounce: 2-flop sync, stable-level debouncer and registered rising-edge press pulse.
module debounce
   import debug_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
)
(
   input  logic clock,
   input  logic reset,
   input  logic btn_i,
   output logic press_o
);
   localparam logic [DBC_W-1:0] LAST = DBC_W'(DEBOUNCE_CYCLES - 1);
   logic [1:0]       sync_q;
   logic             stable_q, stable_d, prev_q, press_q, diff, hit;
   logic [DBC_W-1:0] cnt_q, cnt_d;
   always_comb begin
      diff     = sync_q[1] ^ stable_q;
      hit      = diff && cnt_q == LAST;
      stable_d = hit ? sync_q[1] : stable_q;
      cnt_d    = (diff && !hit) ? cnt_q + 1'b1 : '0;
   end
   // press is registered one edge after the stable update so step latency is DEBOUNCE_CYCLES+4
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         sync_q   <= '0;
         stable_q <= 1'b0;
         prev_q   <= 1'b0;
         press_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q   <= {sync_q[0], btn_i};
         stable_q <= stable_d;
         prev_q   <= stable_q;
         press_q  <= stable_q & ~prev_q;
         cnt_q    <= cnt_d;
      end
   assign press_o = press_q;
endmodule

// File: rtl/debug_in.sv
// debug_in: button front end producing CPU step enables, display select and clock count.
// Free-run mode and the run button exist only when DEBUG_IN_AUTORUN_EN is defined.
module debug_in
   import debug_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
)
(
   input logic       clock,
   input logic       reset,
   debug_in_if.slave dbg
);
   logic        step_p, mode_p, run_p, run_d;
   logic        run_q, en_q, en_d;
   step_state_t state_q, state_d;
   logic [1:0]  disp_q, disp_d;
   logic [7:0]  cnt_q;
   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
      .clock, .reset, .btn_i(dbg.btn_step), .press_o(step_p));
   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
      .clock, .reset, .btn_i(dbg.btn_mode), .press_o(mode_p));
`ifdef DEBUG_IN_AUTORUN_EN
   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
      .clock, .reset, .btn_i(dbg.btn_run), .press_o(run_p));
   assign run_d = run_q ^ run_p;
`else
   logic unused_run;
   assign unused_run = dbg.btn_run;
   assign run_p      = 1'b0;
   assign run_d      = 1'b0;
`endif
   // a run press in the same cycle as a step press swallows the step
   always_comb begin
      state_d = (state_q == STEP_IDLE && step_p && !run_q && !run_p) ? STEP_FIRE : STEP_IDLE;
      disp_d  = disp_q + {1'b0, mode_p};
      en_d    = run_d || state_d == STEP_FIRE;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state_q <= STEP_IDLE;
         run_q   <= 1'b0;
         en_q    <= 1'b0;
         disp_q  <= DISP_TEST_LO;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         en_q    <= en_d;
         disp_q  <= disp_d;
         cnt_q   <= cnt_q + {7'd0, en_q};
      end
   assign dbg.cpu_clock_en     = en_q;
   assign dbg.run_mode         = run_q;
   assign dbg.disp_control     = disp_q;
   assign dbg.disp_clock_count = cnt_q;
endmodule
